// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx_if : payload handshake and serial-line bundle for seq_pattern_tx
// Rev 1.0
// ============================================================================
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              x;
  logic              x_valid;
  logic              busy;
  logic              done;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx : frames a payload as preamble + MSB-first data + gap zeros on x.
// Optional even-parity bit after the data when SEQ_TX_PARITY_EN is defined. Rev 1.0
// ============================================================================
module seq_pattern_tx #(
  parameter int               DATA_W       = 8,
  parameter int               PRE_W        = 4,
  parameter logic [PRE_W-1:0] PRE_PATTERN  = 4'b1101,
  parameter int               CLKS_PER_BIT = 1,
  parameter int               GAP_BITS     = 2
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int MAX_PD  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_BITS) ? MAX_PD : GAP_BITS;
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TICK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  PRE_LAST  = IDX_W'(PRE_W - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  GAP_LAST  = IDX_W'(((GAP_BITS > 0) ? GAP_BITS : 1) - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // With no gap bits the frame ends directly after the last payload/parity bit.
  localparam logic [2:0] S_TAIL = (GAP_BITS > 0) ? S_GAP : S_IDLE;
`ifdef SEQ_TX_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PAR;
`else
  localparam logic [2:0] S_AFTER_DATA = S_TAIL;
`endif

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic [PRE_W-1:0]  pre_sh, pre_nxt;
  logic [DATA_W-1:0] data_sh, data_nxt;
  logic              x_nxt;
  logic              accept;
  logic              frame_end;
`ifdef SEQ_TX_PARITY_EN
  logic              par_bit;
`endif

  assign bus.in_ready = (state == S_IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign frame_end    = (state != S_IDLE) && (state_nxt == S_IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tick_nxt  = tick;
    pre_nxt   = pre_sh;
    data_nxt  = data_sh;
    if (state == S_IDLE) begin
      if (accept) begin
        state_nxt = S_PRE;
        idx_nxt   = '0;
        tick_nxt  = '0;
        pre_nxt   = PRE_PATTERN;
        data_nxt  = bus.in_data;
      end
    end else if (tick == TICK_LAST) begin
      tick_nxt = '0;
      idx_nxt  = idx + 1'b1;
      case (state)
        S_PRE: begin
          if (idx == PRE_LAST) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end else begin
            pre_nxt = pre_sh << 1;
          end
        end
        S_DATA: begin
          if (idx == DATA_LAST) begin
            state_nxt = S_AFTER_DATA;
            idx_nxt   = '0;
          end else begin
            data_nxt = data_sh << 1;
          end
        end
        S_PAR: begin
          state_nxt = S_TAIL;
          idx_nxt   = '0;
        end
        S_GAP: begin
          if (idx == GAP_LAST) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      tick_nxt = tick + 1'b1;
    end
  end

  // Line value is registered from the upcoming state so the first bit lands one cycle after accept.
  always_comb begin
    x_nxt = 1'b0;
    case (state_nxt)
      S_PRE:  x_nxt = pre_nxt[PRE_W-1];
      S_DATA: x_nxt = data_nxt[DATA_W-1];
`ifdef SEQ_TX_PARITY_EN
      S_PAR:  x_nxt = par_bit;
`endif
      default: x_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      tick        <= '0;
      pre_sh      <= '0;
      data_sh     <= '0;
      bus.x       <= 1'b0;
      bus.x_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      tick        <= tick_nxt;
      pre_sh      <= pre_nxt;
      data_sh     <= data_nxt;
      bus.x       <= x_nxt;
      bus.x_valid <= (state_nxt == S_PRE) || (state_nxt == S_DATA) || (state_nxt == S_PAR);
      bus.busy    <= (state_nxt != S_IDLE);
      bus.done    <= frame_end;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^bus.in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_tx : randomized frame checks of seq_pattern_tx against a bit-level model.
// Rev 1.0
// ============================================================================
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 12 + P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.DATA_W(8)) bus_a ();
  seq_pattern_tx_if #(.DATA_W(8)) bus_b ();
  seq_pattern_tx_if #(.DATA_W(8)) bus_c ();

  seq_pattern_tx dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_pattern_tx #(.CLKS_PER_BIT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  seq_pattern_tx #(.GAP_BITS(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Bit at frame position pos: preamble 1101, payload MSB-first, optional even parity, zeros after.
  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    if (pos < 4)               return logic'((13 >> (3 - pos)) & 1);
    if (pos < 12)              return logic'((int'(d) >> (11 - pos)) & 1);
    if (P == 1 && pos == 12)   return ^d;
    return 1'b0;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus_a.in_ready, bus_a.busy, bus_a.done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: got ready/busy/done %b want 100", {bus_a.in_ready, bus_a.busy, bus_a.done});
    end
  endtask

  task automatic test_frame(input logic [7:0] d);
    int f = NBITS + 2;
    logic [4:0] exp;
    @(negedge clk);
    vectors++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready_pre: got %b want 1", bus_a.in_ready);
    end
    bus_a.in_data  = d;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'($urandom);
    for (int k = 1; k <= f; k++) begin
      exp = {exp_bit(d, k - 1), (k - 1) < NBITS, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== exp) begin
        errors++;
        $display("FAIL frame_bit d=%h k=%0d: got x/v/busy/done/rdy %b want %b", d, k,
                 {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready}, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== 5'b00011) begin
      errors++;
      $display("FAIL frame_done d=%h: got %b want 00011", d, {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready});
    end
    @(negedge clk);
    vectors++;
    if (bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse d=%h: got %b want 0", d, bus_a.done);
    end
  endtask

  task automatic test_busy_ignore();
    int f = NBITS + 2;
    logic [7:0] d0 = 8'($urandom);
    logic [7:0] d1;
    logic [4:0] exp;
    @(negedge clk);
    bus_a.in_data  = d0;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= f; k++) begin
      exp = {exp_bit(d0, k - 1), (k - 1) < NBITS, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== exp) begin
        errors++;
        $display("FAIL busy_ignore_bit k=%0d: got %b want %b", k,
                 {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready}, exp);
      end
      bus_a.in_data = 8'($urandom);
      @(negedge clk);
    end
    vectors++;
    if ({bus_a.done, bus_a.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL busy_ignore_done: got done/rdy %b want 11", {bus_a.done, bus_a.in_ready});
    end
    d1 = bus_a.in_data;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int k = 1; k <= f; k++) begin
      exp = {exp_bit(d1, k - 1), (k - 1) < NBITS, 1'b1, 1'b0, 1'b0};
      vectors++;
      if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== exp) begin
        errors++;
        $display("FAIL second_frame_bit k=%0d: got %b want %b", k,
                 {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready}, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if ({bus_a.done, bus_a.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL second_frame_done: got done/rdy %b want 11", {bus_a.done, bus_a.in_ready});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d = 8'($urandom);
    int stray = 0;
    @(negedge clk);
    bus_a.in_data  = d;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b want 00000", {bus_a.x, bus_a.x_valid, bus_a.busy, bus_a.done, bus_a.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus_a.in_ready, bus_a.busy, bus_a.done} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_release: got rdy/busy/done %b want 100", {bus_a.in_ready, bus_a.busy, bus_a.done});
    end
    for (int i = 0; i < 20; i++) begin
      if (bus_a.done !== 1'b0 || bus_a.x_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    vectors++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_slow_bits();
    int f = (NBITS + 2) * 3;
    logic [7:0] d = 8'h80;
    logic [3:0] exp;
    @(negedge clk);
    bus_b.in_data  = d;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    for (int k = 1; k <= f; k++) begin
      exp = {exp_bit(d, (k - 1) / 3), ((k - 1) / 3) < NBITS, 1'b1, 1'b0};
      vectors++;
      if ({bus_b.x, bus_b.x_valid, bus_b.busy, bus_b.done} !== exp) begin
        errors++;
        $display("FAIL slow_bit k=%0d: got x/v/busy/done %b want %b", k,
                 {bus_b.x, bus_b.x_valid, bus_b.busy, bus_b.done}, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if ({bus_b.done, bus_b.in_ready, bus_b.busy} !== 3'b110) begin
      errors++;
      $display("FAIL slow_done: got done/rdy/busy %b want 110", {bus_b.done, bus_b.in_ready, bus_b.busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] want;
    int sr = 0, cnt = 0, frames = 0, idle_run = 0;
    bus_c.in_valid = 1'b1;
    bus_c.in_data  = 8'($urandom);
    if (bus_c.in_ready === 1'b1) sent.push_back(bus_c.in_data);
    for (int cyc = 0; cyc < 400 && frames < 12; cyc++) begin
      @(negedge clk);
      if (bus_c.x_valid === 1'b1) begin
        if (frames > 0 && idle_run > 0) begin
          vectors++;
          if (idle_run !== 1) begin
            errors++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles want 1", idle_run);
          end
        end
        idle_run = 0;
        sr  = (sr << 1) | int'(bus_c.x);
        cnt++;
        if (cnt == NBITS) begin
          want = (sent.size() > 0) ? sent.pop_front() : 8'hxx;
          vectors++;
          if (((sr >> (8 + P)) & 15) !== 13 || 8'((sr >> P) & 255) !== want ||
              (P == 1 && (sr & 1) !== int'(^want))) begin
            errors++;
            $display("FAIL b2b_frame %0d: got bits %h want payload %h", frames, sr, want);
          end
          frames++;
          sr  = 0;
          cnt = 0;
        end
      end else begin
        idle_run++;
        if (frames > 0 && idle_run == 1) begin
          vectors++;
          if ({bus_c.x, bus_c.done, cnt != 0} !== 3'b010) begin
            errors++;
            $display("FAIL b2b_idle_cycle: got x/done/partial %b want 010", {bus_c.x, bus_c.done, cnt != 0});
          end
        end
      end
      bus_c.in_data = 8'($urandom);
      if (bus_c.in_ready === 1'b1) sent.push_back(bus_c.in_data);
    end
    bus_c.in_valid = 1'b0;
    vectors++;
    if (frames < 12) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d frames want 12", frames);
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_frame(8'h00);
    test_frame(8'hFF);
    for (int i = 0; i < 4; i++) test_frame(8'($urandom));
    test_busy_ignore();
    test_mid_reset();
    test_slow_bits();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
